// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC pipeline: opcodes, the issue FSM
// states and decode helpers that say which register fields an opcode uses.
package risc_pkg;

    localparam int unsigned REG_AW_DEF = 4;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_LDI = 4'b0011;
    localparam logic [3:0] OP_STI = 4'b0100;
    localparam logic [3:0] OP_LDM = 4'b0101;
    localparam logic [3:0] OP_STM = 4'b0111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2
    } issue_state_e;

    // Source 1 field is a register operand (STI uses it as an immediate).
    function automatic logic op_reads_r1(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_STM);
    endfunction

    function automatic logic op_reads_r2(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_writes_rd(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LDI) || (op == OP_LDM);
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register busy scoreboard. A retire clear is applied before an issue set,
// so a same-cycle set of the same register wins. Read ports see the
// write-first view (this cycle's clear already applied).
module id_scoreboard
    import risc_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_AW   = REG_AW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_reg,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_reg,
    input  logic [REG_AW-1:0]   rs1_addr,
    input  logic [REG_AW-1:0]   rs2_addr,
    input  logic [REG_AW-1:0]   rd_addr,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic                rd_busy,
    output logic [NUM_REGS-1:0] busy,
    output logic                clr_err
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] clr_mask, set_mask, busy_eff;

    // Bypassed view, lookups, error detect and next busy vector.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en) clr_mask[clr_reg] = 1'b1;
        if (set_en) set_mask[set_reg] = 1'b1;
        busy_eff = busy_q & ~clr_mask;
        rs1_busy = busy_eff[rs1_addr];
        rs2_busy = busy_eff[rs2_addr];
        rd_busy  = busy_eff[rd_addr];
        clr_err  = clr_en & ~busy_q[clr_reg];
        busy_d   = busy_eff | set_mask;
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/id_issue_controller.sv
// Decode-to-Execute issue controller: RAW/WAW/full-pipe stall, flush drain,
// in-flight counting and sticky retire-protocol error.
// Optional feature macro: ID_ISSUE_PERF_EN (stall-cycle perf counter).
module id_issue_controller
    import risc_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [3:0]             id_opcode,
    input  logic [REG_AW-1:0]      id_read_reg1,
    input  logic [REG_AW-1:0]      id_read_reg2,
    input  logic [REG_AW-1:0]      id_reg_addr,
    input  logic                   ex_ready,
    input  logic                   flush,
    input  logic                   retire_valid,
    input  logic                   retire_we,
    input  logic [REG_AW-1:0]      retire_reg,
    output logic                   issue,
    output logic                   id_stall,
    output logic [NUM_REGS-1:0]    busy,
    output logic [3:0]             inflight,
    output logic                   protocol_err,
    output logic [STALL_CNT_W-1:0] perf_stall_cnt
);

    localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT);

    issue_state_e st_q, st_d;
    logic [3:0]   inflight_q, inflight_d;
    logic         perr_q, perr_d;

    logic retire_ok, clr_en, set_en, full, hazard;
    logic rs1_busy, rs2_busy, rd_busy, clr_err;

    id_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .clr_en   (clr_en),
        .clr_reg  (retire_reg),
        .set_en   (set_en),
        .set_reg  (id_reg_addr),
        .rs1_addr (id_read_reg1),
        .rs2_addr (id_read_reg2),
        .rd_addr  (id_reg_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .busy     (busy),
        .clr_err  (clr_err)
    );

    // Hazard detect and issue decision; a retire with nothing in flight is ignored.
    always_comb begin
        retire_ok = retire_valid & (inflight_q != 4'd0);
        clr_en    = retire_ok & retire_we;
        full      = (inflight_q == MAX_IF) & ~retire_valid;
        hazard    = (op_reads_r1(id_opcode) & rs1_busy) |
                    (op_reads_r2(id_opcode) & rs2_busy) |
                    (op_writes_rd(id_opcode) & rd_busy) |
                    full;
        issue     = ~reset & id_valid & ex_ready & ~hazard & ~flush &
                    (st_q != ST_DRAIN);
        id_stall  = id_valid & ~issue;
        set_en    = issue & op_writes_rd(id_opcode);
    end

    // Next-state logic: flush overrides every state.
    always_comb begin
        st_d = st_q;
        if (flush) begin
            st_d = ST_DRAIN;
        end else begin
            case (st_q)
                ST_RUN:   if (id_valid & hazard) st_d = ST_STALL;
                ST_STALL: if (issue) st_d = ST_RUN;
                ST_DRAIN: if ((inflight_q == 4'd0) & ~retire_valid) st_d = ST_RUN;
                default:  st_d = ST_RUN;
            endcase
        end
    end

    // In-flight counter and sticky protocol-error next values.
    always_comb begin
        inflight_d = inflight_q;
        case ({issue, retire_ok})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase
        perr_d = perr_q | (retire_valid & (inflight_q == 4'd0)) | clr_err;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q       <= ST_RUN;
            inflight_q <= 4'd0;
            perr_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            inflight_q <= inflight_d;
            perr_q     <= perr_d;
        end
    end

    assign inflight     = inflight_q;
    assign protocol_err = perr_q;

`ifdef ID_ISSUE_PERF_EN
    logic [STALL_CNT_W-1:0] perf_q, perf_d;

    // Saturating count of stalled decode cycles outside DRAIN.
    always_comb begin
        perf_d = perf_q;
        if (id_stall && (st_q != ST_DRAIN) && (perf_q != '1))
            perf_d = perf_q + 1'b1;
    end

    // Perf counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_issue_controller.sv
// Randomised self-checking bench for id_issue_controller with a behavioural
// model of the issue rules, plus directed scenarios with literal expectations.
module tb_id_issue_controller;

    localparam int MAXI = 4;
`ifdef ID_ISSUE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_opcode = '0;
    logic [3:0]  id_read_reg1 = '0, id_read_reg2 = '0, id_reg_addr = '0;
    logic        ex_ready = 1'b0, flush = 1'b0;
    logic        retire_valid = 1'b0, retire_we = 1'b0;
    logic [3:0]  retire_reg = '0;
    logic        issue, id_stall, protocol_err;
    logic [15:0] busy;
    logic [3:0]  inflight;
    logic [15:0] perf_stall_cnt;

    always #5 clk = ~clk;

    id_issue_controller #(
        .NUM_REGS     (16),
        .REG_AW       (4),
        .MAX_INFLIGHT (MAXI),
        .STALL_CNT_W  (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_read_reg1   (id_read_reg1),
        .id_read_reg2   (id_read_reg2),
        .id_reg_addr    (id_reg_addr),
        .ex_ready       (ex_ready),
        .flush          (flush),
        .retire_valid   (retire_valid),
        .retire_we      (retire_we),
        .retire_reg     (retire_reg),
        .issue          (issue),
        .id_stall       (id_stall),
        .busy           (busy),
        .inflight       (inflight),
        .protocol_err   (protocol_err),
        .perf_stall_cnt (perf_stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = running, 1 = stalled, 2 = draining.
    bit mbusy[16];
    int minfl, mmode, mperf;
    bit merr;
    bit e_issue, e_haz, rok;
    int clr;

    logic        s_issue, s_stall, s_err;
    logic [15:0] s_busy;
    logic [3:0]  s_infl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rd1(input int op);
        return op == 1 || op == 2 || op == 7;
    endfunction
    function automatic bit rd2(input int op);
        return op == 1 || op == 2;
    endfunction
    function automatic bit wr(input int op);
        return op == 1 || op == 2 || op == 3 || op == 5;
    endfunction

    function automatic bit beff(input int r);
        return mbusy[r] && (r != clr);
    endfunction

    function automatic logic [15:0] mbusy_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = mbusy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mbusy[i] = 1'b0;
        minfl = 0; mmode = 0; mperf = 0; merr = 1'b0;
    endtask

    task automatic model_eval();
        int o;
        o   = int'(id_opcode);
        rok = retire_valid && (minfl > 0);
        clr = (rok && retire_we) ? int'(retire_reg) : -1;
        e_haz = (rd1(o) && beff(int'(id_read_reg1))) ||
                (rd2(o) && beff(int'(id_read_reg2))) ||
                (wr(o)  && beff(int'(id_reg_addr)))  ||
                (minfl == MAXI && !retire_valid);
        e_issue = id_valid && ex_ready && !e_haz && !flush && (mmode != 2);
    endtask

    task automatic model_update();
        model_eval();
        if (retire_valid && minfl == 0) merr = 1'b1;
        if (rok && retire_we && !mbusy[retire_reg]) merr = 1'b1;
        if (PERF && id_valid && !e_issue && mmode != 2 && mperf < 65535) mperf++;
        if (flush) mmode = 2;
        else if (mmode == 0) begin
            if (id_valid && e_haz) mmode = 1;
        end else if (mmode == 1) begin
            if (e_issue) mmode = 0;
        end else if (minfl == 0 && !retire_valid) mmode = 0;
        if (clr >= 0) mbusy[clr] = 1'b0;
        if (e_issue && wr(int'(id_opcode))) mbusy[id_reg_addr] = 1'b1;
        minfl = minfl + int'(e_issue) - int'(rok);
    endtask

    task automatic compare_all();
        model_eval();
        s_issue = issue; s_stall = id_stall; s_busy = busy;
        s_infl = inflight; s_err = protocol_err;
        chk("issue", issue, e_issue);
        chk("id_stall", id_stall, id_valid && !e_issue);
        chk("busy", busy, mbusy_vec());
        chk("inflight", inflight, minfl);
        chk("protocol_err", protocol_err, merr);
        chk("perf_stall_cnt", perf_stall_cnt, mperf);
    endtask

    task automatic cyc(input bit v, input int op, input int r1, input int r2, input int rd,
                       input bit exr, input bit fl, input bit rv, input bit rwe, input int rr);
        @(negedge clk);
        id_valid = v; id_opcode = 4'(op);
        id_read_reg1 = 4'(r1); id_read_reg2 = 4'(r2); id_reg_addr = 4'(rd);
        ex_ready = exr; flush = fl;
        retire_valid = rv; retire_we = rwe; retire_reg = 4'(rr);
        #1;
        compare_all();
        @(posedge clk);
        model_update();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    // Asserted shortly after a rising edge with inputs still live.
    task automatic async_reset();
        #3;
        reset = 1'b1;
        #1;
        chk("rst_issue", issue, 1'b0);
        chk("rst_busy", busy, 16'h0000);
        chk("rst_inflight", inflight, 4'd0);
        chk("rst_protocol_err", protocol_err, 1'b0);
        chk("rst_perf", perf_stall_cnt, 16'h0000);
        model_reset();
        @(negedge clk);
        id_valid = 0; flush = 0; retire_valid = 0; retire_we = 0; ex_ready = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        async_reset();

        // RAW stall released by a same-cycle retire of the source.
        cyc(1, 1, 1, 2, 3, 1, 0, 0, 0, 0);  chk("t1_add_issue", s_issue, 1);
        cyc(1, 2, 3, 4, 5, 1, 0, 0, 0, 0);  chk("t1_sub_stall1", s_stall, 1);
        cyc(1, 2, 3, 4, 5, 1, 0, 0, 0, 0);  chk("t1_sub_stall2", s_stall, 1);
        cyc(1, 2, 3, 4, 5, 1, 0, 1, 1, 3);  chk("t1_sub_bypass", s_issue, 1);
        chk("t1_busy_pre", s_busy, 16'h0008);
        idle();                             chk("t1_busy_post", s_busy, 16'h0020);
        chk("t1_inflight", s_infl, 4'd1);
        async_reset();

        // WAW on R6; set wins over a same-cycle clear.
        cyc(1, 3, 0, 0, 6, 1, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 6, 1, 0, 0, 0, 0);  chk("t2_waw_stall", s_stall, 1);
        cyc(1, 3, 0, 0, 6, 1, 0, 1, 1, 6);  chk("t2_issue", s_issue, 1);
        idle();                             chk("t2_busy6", s_busy, 16'h0040);
        chk("t2_inflight", s_infl, 4'd1);
        async_reset();

        // Full pipe.
        for (int i = 0; i < 4; i++) cyc(1, 3, 0, 0, i, 1, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 4, 1, 0, 0, 0, 0);  chk("t3_full_stall", s_issue, 0);
        chk("t3_inflight4", s_infl, 4'd4);
        cyc(1, 3, 0, 0, 4, 1, 0, 1, 1, 0);  chk("t3_issue_w_retire", s_issue, 1);
        idle();                             chk("t3_inflight_hold", s_infl, 4'd4);
        chk("t3_busy", s_busy, 16'h001E);
        async_reset();

        // Flush and drain.
        cyc(1, 3, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 2, 1, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 7, 1, 1, 0, 0, 0);  chk("t4_flush_noissue", s_issue, 0);
        cyc(1, 3, 0, 0, 7, 1, 0, 1, 1, 1);  chk("t4_drain1", s_issue, 0);
        cyc(1, 3, 0, 0, 7, 1, 0, 1, 1, 2);  chk("t4_drain2", s_issue, 0);
        cyc(1, 3, 0, 0, 7, 1, 0, 0, 0, 0);  chk("t4_drain_exit", s_issue, 0);
        chk("t4_busy0", s_busy, 16'h0000);
        cyc(1, 3, 0, 0, 7, 1, 0, 0, 0, 0);  chk("t4_run_issue", s_issue, 1);
        async_reset();

        // Protocol errors.
        cyc(1, 3, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 1, 1, 9);
        idle();                             chk("t5_err_nonbusy", s_err, 1);
        chk("t5_busy_kept", s_busy, 16'h0002);
        async_reset();
        cyc(0, 0, 0, 0, 0, 1, 0, 1, 1, 2);
        idle();                             chk("t5_err_empty", s_err, 1);
        chk("t5_inflight0", s_infl, 4'd0);
        idle();                             chk("t5_err_sticky", s_err, 1);
        async_reset();

        // Reset mid-stall.
        cyc(1, 3, 0, 0, 3, 1, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 5, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3, 0, 0, 3, 1, 0, 0, 0, 0);
            chk("t6_busy28", s_busy, 16'h0028);
        end
        #1;
        chk("t6_perf3", perf_stall_cnt, PERF ? 16'd3 : 16'd0);
        async_reset();

        // Randomised run against the model.
        for (int n = 0; n < 3000; n++) begin
            bit v, exr, fl, rv, rwe;
            int op, r1, r2, rd, rr, nb, k;
            if (n % 400 == 399) async_reset();
            v   = $urandom_range(0, 9) < 7;
            op  = $urandom_range(0, 15);
            r1  = $urandom_range(0, 15);
            r2  = $urandom_range(0, 15);
            rd  = $urandom_range(0, 15);
            exr = $urandom_range(0, 9) < 8;
            fl  = $urandom_range(0, 99) < 3;
            rv = 0; rwe = 0; rr = $urandom_range(0, 15);
            nb = 0;
            for (int i = 0; i < 16; i++) nb += int'(mbusy[i]);
            if (minfl > 0) begin
                rv = $urandom_range(0, 9) < 4;
                if (nb > 0 && (nb >= minfl || $urandom_range(0, 9) < 7)) begin
                    rwe = 1;
                    k = $urandom_range(0, nb - 1);
                    for (int i = 0; i < 16; i++) begin
                        if (mbusy[i]) begin
                            if (k == 0) rr = i;
                            k--;
                        end
                    end
                end
                if ($urandom_range(0, 99) < 2) begin
                    rwe = 1;
                    rr = $urandom_range(0, 15);
                end
            end else begin
                rv = $urandom_range(0, 99) < 1;
            end
            cyc(v, op, r1, r2, rd, exr, fl, rv, rwe, rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
